// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RISC-V sequencer: states, opcodes,
// ALUOp codes and error codes.
package multicycle_control_fsm_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_IMEM    = 2'b10;
    localparam logic [1:0] ERR_DMEM    = 2'b11;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LD) ||
               (op == OP_SD) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Wait-cycle counter shared by FETCH and MEM; flags the cycle whose miss
// would bring the count up to the limit.
module mem_wait_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!reset || clear)
            count <= 8'd0;
        else if (enable)
            count <= count + 8'd1;
    end

    // Combinational so the FSM can leave for HALT on the same edge the
    // limit-th miss is counted.
    assign expired = enable && (count == limit - 8'd1);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer for the 64-bit RISC-V datapath: steps
// FETCH/DECODE/EXEC/MEM/WB with ready handshakes, retire count and error halt.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             reg_write,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_to_reg,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    state_t     state_q, state_n;
    logic       retire;
    logic [1:0] err_n;
    logic       wait_en, wait_clr, wait_expired;

    assign state    = state_q;
    assign wait_en  = ((state_q == S_FETCH) && !imem_ready) ||
                      ((state_q == S_MEM)   && !dmem_ready);
    assign wait_clr = (state_n != state_q);

    mem_wait_timer u_wait (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clr),
        .enable  (wait_en),
        .limit   (TIMEOUT_LIM),
        .expired (wait_expired)
    );

    always_comb begin
        state_n    = state_q;
        err_n      = ERR_NONE;
        retire     = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        mem_to_reg = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        case (state_q)
            S_IDLE: if (run) state_n = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                // A ready arriving on the timeout cycle still completes the fetch.
                if (imem_ready)
                    state_n = S_DECODE;
                else if (wait_expired) begin
                    state_n = S_HALT;
                    err_n   = ERR_IMEM;
                end
            end
            S_DECODE: begin
                if (is_legal(opcode))
                    state_n = S_EXEC;
                else begin
                    state_n = S_HALT;
                    err_n   = ERR_ILLEGAL;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_R: begin
                        alu_op  = ALU_FUNCT;
                        state_n = S_WB;
                    end
                    OP_I: begin
                        alu_src = 1'b1;
                        alu_op  = ALU_FUNCT;
                        state_n = S_WB;
                    end
                    OP_LD, OP_SD: begin
                        alu_src = 1'b1;
                        state_n = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op   = ALU_SUB;
                        pc_write = 1'b1;
                        pc_src   = zero;
                        retire   = 1'b1;
                    end
                    default: begin
                        state_n = S_HALT;
                        err_n   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_SD);
                alu_src  = 1'b1;
                if (dmem_ready) begin
                    if (opcode == OP_SD) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end else
                        state_n = S_WB;
                end else if (wait_expired) begin
                    state_n = S_HALT;
                    err_n   = ERR_DMEM;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode == OP_LD);
                pc_write   = 1'b1;
                retire     = 1'b1;
            end
            S_HALT: ;
            default: state_n = S_IDLE;
        endcase
        if (retire)
            state_n = run ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            halted        <= 1'b0;
            err_code      <= ERR_NONE;
            retired_count <= '0;
        end else begin
            state_q <= state_n;
            if (retire)
                retired_count <= retired_count + {{(CNT_W-1){1'b0}}, 1'b1};
            if (state_n == S_HALT && state_q != S_HALT) begin
                halted   <= 1'b1;
                err_code <= err_n;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed scenarios plus randomized traffic checked every cycle against a
// route-table model of the instruction sequencer.
module tb_multicycle_control_fsm;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0, run = 1'b0, zero = 1'b0;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        pc_write, pc_src, ir_write, reg_write, alu_src, mem_to_reg;
    logic        imem_req, dmem_req, dmem_we, halted;
    logic [1:0]  alu_op, err_code;
    logic [2:0]  state;
    logic [31:0] retired_count;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .reg_write(reg_write), .alu_src(alu_src), .alu_op(alu_op),
        .mem_to_reg(mem_to_reg), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .halted(halted), .err_code(err_code),
        .state(state), .retired_count(retired_count)
    );

    int n_tests = 0, n_fail = 0, cycle_no = 0;
    bit primed = 0;

    // Model: mode 0 idle, 1 running an instruction, 2 halted.
    // An instruction is a route of phase letters (1 F, 2 D, 3 E, 4 M, 5 W).
    int m_mode = 0, m_pos = 0, m_wait = 0, m_err = 0;
    int unsigned m_cnt = 0;

    int h_state[64], h_pcw[64], h_pcsrc[64], h_regw[64], h_dreq[64], h_m2r[64];
    int h_halt[64], h_err[64];
    longint h_cnt[64];
    int hidx = 0;

    localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD_OP = 7'b0000011;
    localparam logic [6:0] SD_OP = 7'b0100011, BEQ_OP = 7'b1100011;

    function automatic int cls_of(input logic [6:0] op);
        case (op)
            R_OP:    return 0;
            I_OP:    return 1;
            LD_OP:   return 2;
            SD_OP:   return 3;
            BEQ_OP:  return 4;
            default: return 5;
        endcase
    endfunction

    function automatic int route_len(input int c);
        case (c)
            0, 1, 3: return 4;
            2:       return 5;
            4:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int route_at(input int c, input int i);
        if (i == 0) return 1;
        if (i == 1) return 2;
        if (i == 2) return 3;
        if (i == 3) return (c == 2 || c == 3) ? 4 : 5;
        return 5;
    endfunction

    function automatic int cur_letter();
        if (m_mode == 0) return 0;
        if (m_mode == 2) return 6;
        return route_at(cls_of(opcode), m_pos);
    endfunction

    // {state, halted, err, pc_write, pc_src, ir_write, reg_write, alu_src,
    //  alu_op, mem_to_reg, imem_req, dmem_req, dmem_we}
    function automatic logic [16:0] expect_vec();
        int L, c;
        logic pcw, pcs, irw, rw, as, m2r, ireq, dreq, we;
        logic [1:0] aop;
        L = cur_letter();
        c = cls_of(opcode);
        {pcw, pcs, irw, rw, as, m2r, ireq, dreq, we} = '0;
        aop = 2'b00;
        case (L)
            1: begin ireq = 1; irw = imem_ready; end
            3: begin
                if (c == 0 || c == 1) begin aop = 2'b10; as = (c == 1); end
                else if (c == 2 || c == 3) as = 1;
                else if (c == 4) begin aop = 2'b01; pcw = 1; pcs = zero; end
            end
            4: begin dreq = 1; we = (c == 3); as = 1; pcw = (c == 3) && dmem_ready; end
            5: begin rw = 1; m2r = (c == 2); pcw = 1; end
            default: ;
        endcase
        return {3'(L), (m_mode == 2), 2'(m_err), pcw, pcs, irw, rw, as, aop,
                m2r, ireq, dreq, we};
    endfunction

    task automatic model_step();
        int L, c;
        bit adv;
        if (!reset) begin
            m_mode = 0; m_pos = 0; m_wait = 0; m_err = 0; m_cnt = 0;
            return;
        end
        L = cur_letter();
        c = cls_of(opcode);
        adv = 0;
        if (m_mode == 0) begin
            if (run) begin m_mode = 1; m_pos = 0; m_wait = 0; end
        end else if (m_mode == 1) begin
            if (L == 1 || L == 4) begin
                if ((L == 1) ? imem_ready : dmem_ready) adv = 1;
                else begin
                    m_wait++;
                    if (m_wait == TMO) begin m_mode = 2; m_err = (L == 1) ? 2 : 3; end
                end
            end else if (L == 2) begin
                if (c == 5) begin m_mode = 2; m_err = 1; end
                else adv = 1;
            end else adv = 1;
            if (adv) begin
                m_wait = 0;
                m_pos++;
                if (m_pos == route_len(c)) begin
                    m_cnt++;
                    m_pos = 0;
                    if (!run) m_mode = 0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic rn, input logic [6:0] op,
                       input logic ir, input logic dr, input logic z);
        logic [16:0] got, exp;
        @(negedge clk);
        reset = r; run = rn; opcode = op; imem_ready = ir; dmem_ready = dr; zero = z;
        #1;
        cycle_no++;
        if (hidx < 64) begin
            h_state[hidx] = int'(state);   h_pcw[hidx] = int'(pc_write);
            h_pcsrc[hidx] = int'(pc_src);  h_regw[hidx] = int'(reg_write);
            h_dreq[hidx] = int'(dmem_req); h_m2r[hidx] = int'(mem_to_reg);
            h_halt[hidx] = int'(halted);   h_err[hidx] = int'(err_code);
            h_cnt[hidx] = longint'(retired_count);
            hidx++;
        end
        if (primed) begin
            got = {state, halted, err_code, pc_write, pc_src, ir_write, reg_write,
                   alu_src, alu_op, mem_to_reg, imem_req, dmem_req, dmem_we};
            exp = expect_vec();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d got=%h expected=%h", cycle_no, got, exp);
            end
            n_tests++;
            if (retired_count !== m_cnt) begin
                n_fail++;
                $display("FAIL retired_count cyc=%0d got=%0d expected=%0d",
                         cycle_no, retired_count, m_cnt);
            end
        end
        model_step();
        if (!r) primed = 1;
    endtask

    task automatic do_reset();
        cyc(0, 0, 7'd0, 0, 0, 0);
        cyc(0, 0, 7'd0, 0, 0, 0);
        hidx = 0;
    endtask

    int s;
    logic [6:0] rop;
    logic [6:0] legal_ops [5];

    initial begin
        legal_ops = '{R_OP, I_OP, LD_OP, SD_OP, BEQ_OP};

        // R-type, ready tied high
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1, 1, R_OP, 1, 1, 0);
        chk("reset_state", h_state[0], 0);
        chk("reset_count", h_cnt[0], 0);
        chk("reset_halted_err", h_halt[0] + h_err[0], 0);
        chk("r_states", h_state[1]*1000 + h_state[2]*100 + h_state[3]*10 + h_state[4], 1235);
        chk("r_wb_strobes", h_regw[4] + h_pcw[4], 2);
        chk("r_next_fetch", h_state[5], 1);
        chk("r_retired", h_cnt[5], 1);

        // ld with dmem_ready 3 cycles after MEM entry
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1, 1, LD_OP, 1, (i == 7), 0);
        s = 0;
        for (int i = 0; i < 10; i++) s += h_dreq[i];
        chk("ld_dmem_req_cycles", s, 4);
        chk("ld_wb_mem_to_reg", h_state[8]*10 + h_m2r[8], 51);
        chk("ld_total_8", h_state[9]*10 + int'(h_cnt[9]), 11);

        // beq taken then not taken
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 1, BEQ_OP, 1, 1, (i < 4));
        chk("beq_taken", h_pcw[3]*10 + h_pcsrc[3], 11);
        chk("beq_not_taken", h_pcw[6]*10 + h_pcsrc[6], 10);
        s = 0;
        for (int i = 0; i < 8; i++) s += h_regw[i];
        chk("beq_no_reg_write", s, 0);
        chk("beq_3cyc", h_state[4]*10 + h_state[7], 11);
        chk("beq_retired", h_cnt[7], 2);

        // illegal opcode halts; run ignored; reset recovers
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 1, 7'd0, 1, 1, 0);
        for (int i = 0; i < 6; i++) cyc(1, logic'(i % 2), R_OP, 1, 1, 0);
        chk("illegal_halt", h_state[3]*100 + h_halt[3]*10 + h_err[3], 611);
        chk("halt_sticky", h_state[9], 6);
        cyc(0, 1, R_OP, 1, 1, 0);
        cyc(1, 0, R_OP, 1, 1, 0);
        chk("halt_reset", h_state[11]*100 + h_halt[11]*10 + h_err[11], 0);

        // imem timeout, then ready on the 4th wait cycle
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1, 1, R_OP, 0, 1, 0);
        chk("imem_wait", h_state[4], 1);
        chk("imem_timeout", h_state[5]*10 + h_err[5], 62);
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1, 1, R_OP, (i == 4), 1, 0);
        chk("imem_ready_wins", h_state[5]*10 + h_halt[5], 20);

        // reset during MEM of sd
        do_reset();
        for (int i = 0; i < 8; i++) cyc((i != 5), 1, SD_OP, 1, 0, 0);
        chk("sd_mem_req", h_dreq[4] + h_dreq[5], 2);
        chk("sd_abort_idle", h_state[6]*10 + h_dreq[6], 0);
        s = 0;
        for (int i = 0; i < 8; i++) s += h_pcw[i];
        chk("sd_no_pc_write", s, 0);
        chk("sd_abort_count", h_cnt[6], 0);

        // randomized traffic
        do_reset();
        rop = R_OP;
        for (int n = 0; n < 4000; n++) begin
            if (m_mode != 1 || cur_letter() == 1)
                rop = ($urandom_range(0, 9) == 0) ? 7'($urandom)
                                                  : legal_ops[$urandom_range(0, 4)];
            cyc(!(($urandom_range(0, 299) == 0) || (m_mode == 2 && $urandom_range(0, 9) == 0)),
                ($urandom_range(0, 7) != 0), rop,
                ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
                1'($urandom));
            hidx = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
